// File: rtl/nibble_serial_add_if.sv
// Requester and shared 4-bit adder signals of nibble_serial_add_ctrl (ovf present under NIBBLE_SERIAL_ADD_OVF_EN).
// slave = sequencer view; master = requester/adder view.
interface nibble_serial_add_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
  logic             ovf;
`endif
  logic [3:0]       add_x;
  logic [3:0]       add_y;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;

  modport slave (
    input  start, a, b, cin, add_sum, add_cout,
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout, add_x, add_y, add_cin
  );

  modport master (
    output start, a, b, cin, add_sum, add_cout,
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout, add_x, add_y, add_cin
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add over one shared 4-bit adder, LSB nibble first; optional ovf via NIBBLE_SERIAL_ADD_OVF_EN.
// Latency: done in the cycle after the (WIDTH/4)th edge following the accepting edge.
// No backpressure: start is only sampled in IDLE and is dropped (never queued) while busy or done.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  nibble_serial_add_if.slave  bus
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry, cout_reg;
  logic [IW-1:0]    idx;
  logic             accept, last;
  logic [3:0]       nib_a, nib_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Adder inputs are forced to 0 outside RUN so the shared adder sees a quiet bus.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.add_x   = 4'd0;
    bus.add_y   = 4'd0;
    bus.add_cin = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.busy    = 1'b1;
        bus.add_x   = nib_a;
        bus.add_y   = nib_b;
        bus.add_cin = carry;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        nib_a = a_reg[4*i +: 4];
        nib_b = b_reg[4*i +: 4];
      end
    end
  end

  assign last = (idx == IW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      idx      <= '0;
    end else if (accept) begin
      a_reg   <= bus.a;
      b_reg   <= bus.b;
      carry   <= bus.cin;
      sum_reg <= '0;
      idx     <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (idx == IW'(i)) sum_reg[4*i +: 4] <= bus.add_sum;
      end
      carry <= bus.add_cout;
      idx   <= idx + IW'(1);
      if (last) cout_reg <= bus.add_cout;
    end
  end

`ifdef NIBBLE_SERIAL_ADD_OVF_EN
  logic ovf_reg;

  // Signed overflow: operands agree in sign but the top result nibble's sign differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (bus.add_sum[3] != a_reg[WIDTH-1]);
    end
  end

  assign bus.ovf = ovf_reg;
`endif

  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed plus randomized bench for nibble_serial_add_ctrl at WIDTH=16 and WIDTH=4, against an arithmetic model.
module tb_nibble_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  nibble_serial_add_if #(.WIDTH(16)) m16 ();
  nibble_serial_add_if #(.WIDTH(4))  m4 ();

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(m16));
  nibble_serial_add_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(m4));

  // Stand-ins for the external 4-bit ripple adders.
  assign {m16.add_cout, m16.add_sum} = {1'b0, m16.add_x} + {1'b0, m16.add_y} + {4'd0, m16.add_cin};
  assign {m4.add_cout,  m4.add_sum}  = {1'b0, m4.add_x}  + {1'b0, m4.add_y}  + {4'd0, m4.add_cin};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet16(input string tag);
    check({tag, ".busy"},  m16.busy,    0);
    check({tag, ".done"},  m16.done,    0);
    check({tag, ".add_x"}, m16.add_x,   0);
    check({tag, ".add_y"}, m16.add_y,   0);
    check({tag, ".acin"},  m16.add_cin, 0);
  endtask

  // One WIDTH=16 transaction; pulse_at >= 0 re-pulses start with new operands in that RUN cycle.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c, input int pulse_at);
    int unsigned ai, bi, tot, lo, m;
    int sa, sb, ss;
    ai  = a;
    bi  = b;
    tot = ai + bi + c;
    @(negedge clk);
    m16.start = 1'b1; m16.a = a; m16.b = b; m16.cin = c;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m16.start = (k == pulse_at);
      if (k == pulse_at) begin
        m16.a = 16'h1111; m16.b = 16'h1111; m16.cin = 1'b1;
      end
      m  = 32'd1 << (4 * k);
      lo = (ai % m) + (bi % m) + c;
      check($sformatf("run.busy[%0d]", k),  m16.busy,    1);
      check($sformatf("run.done[%0d]", k),  m16.done,    0);
      check($sformatf("run.add_x[%0d]", k), m16.add_x,   (ai >> (4 * k)) & 32'hF);
      check($sformatf("run.add_y[%0d]", k), m16.add_y,   (bi >> (4 * k)) & 32'hF);
      check($sformatf("run.acin[%0d]", k),  m16.add_cin, (lo >> (4 * k)) & 32'h1);
    end
    @(negedge clk);
    m16.start = 1'b0;
    check("done.pulse", m16.done,    1);
    check("done.busy",  m16.busy,    0);
    check("done.add_x", m16.add_x,   0);
    check("done.acin",  m16.add_cin, 0);
    check($sformatf("done.sum %0h+%0h+%0h", a, b, c), m16.sum, tot & 32'hFFFF);
    check($sformatf("done.cout %0h+%0h+%0h", a, b, c), m16.cout, tot >> 16);
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    sa = a[15] ? int'(ai) - 65536 : int'(ai);
    sb = b[15] ? int'(bi) - 65536 : int'(bi);
    ss = sa + sb + int'(c);
    check($sformatf("done.ovf %0h+%0h", a, b), m16.ovf, (ss > 32767 || ss < -32768) ? 1 : 0);
`else
    sa = 0; sb = 0; ss = sa + sb;
`endif
    @(negedge clk);
    check("after.done", m16.done, 0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int unsigned tot;
    tot = a + b + c;
    @(negedge clk);
    m4.start = 1'b1; m4.a = a; m4.b = b; m4.cin = c;
    @(negedge clk);
    m4.start = 1'b0;
    check($sformatf("w4.busy %0h+%0h+%0h", a, b, c), m4.busy, 1);
    @(negedge clk);
    check($sformatf("w4.result %0h+%0h+%0h", a, b, c), {m4.done, m4.cout, m4.sum}, {1'b1, 5'(tot)});
  endtask

  initial begin
    m16.start = 1'b0; m16.a = '0; m16.b = '0; m16.cin = 1'b0;
    m4.start  = 1'b0; m4.a  = '0; m4.b  = '0; m4.cin  = 1'b0;
    rst_n = 1'b0;
    #1;
    check_quiet16("rst");
    check("rst.sum",  m16.sum,  0);
    check("rst.cout", m16.cout, 0);
    check("rst.w4",   {m4.busy, m4.done, m4.cout, m4.sum}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet16("idle");

    run16(16'h1234, 16'h4321, 1'b0, -1);
    run16(16'hFFFF, 16'h0001, 1'b0, -1);
    run16(16'hFFFF, 16'h0000, 1'b1, -1);
    run16(16'h0000, 16'h0000, 1'b0, -1);

    // Start re-pulsed mid-RUN must neither disturb the result nor yield a second done.
    run16(16'h0F0F, 16'h00F1, 1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("ignored.done[%0d]", k), m16.done, 0);
      check($sformatf("ignored.busy[%0d]", k), m16.busy, 0);
    end

    // Leave cout=1 behind, then reset in the second RUN cycle.
    run16(16'hFFFF, 16'h0001, 1'b0, -1);
    @(negedge clk);
    m16.start = 1'b1; m16.a = 16'h1234; m16.b = 16'h4321; m16.cin = 1'b0;
    @(negedge clk);
    m16.start = 1'b0;
    @(negedge clk);
    check("mid.sum_partial", m16.sum, 16'h0005);
    rst_n = 1'b0;
    #1;
    check_quiet16("midrst");
    check("midrst.sum",  m16.sum,  0);
    check("midrst.cout", m16.cout, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midrst.nodone[%0d]", k), m16.done, 0);
    end
    rst_n = 1'b1;
    run16(16'hA5A5, 16'h5A5B, 1'b1, -1);

    for (int n = 0; n < 20; n++) begin
      run16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), -1);
    end

    for (int i = 0; i < 256; i++) begin
      run4(4'(i >> 4), 4'(i), 1'(i));
    end

`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    run16(16'h7FFF, 16'h0001, 1'b0, -1);
    run16(16'h8000, 16'hFFFF, 1'b0, -1);
    run16(16'h7FFF, 16'h0000, 1'b1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
